dmem_responder: RTL and testbench

Data-memory responder for the processor's Memory-stage port: it receives DataAddr, DataOut, ReadData and WriteData, returns DataIn, and stretches every access with DataWaitreq for a fixed, parameterised latency. It sits between the pipelined processor and a single-port word-addressed RAM. It lets the processor's stall-on-Waitreq path run against a real slow memory in simulation and on FPGA.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int ADDR_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dmem_op_t;

    // A simultaneous read and write request is treated as a write.
    function automatic dmem_op_t decodeOp(input logic rd, input logic wr);
        return wr ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: one synchronous write port and one registered read port.
// The storage itself is never reset; only the read register is.
module dmem_array #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic                 i_clr,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The read register doubles as the returned-data holder, so it can also be forced to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else if (i_clr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder stretching each access with DataWaitreq.
// Optional protocol checker enabled by defining DMEM_PROTO_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WORD_SIZE-1:0] i_data_addr,
    input  logic [WORD_SIZE-1:0] i_data_out,
    input  logic                 i_read_data,
    input  logic                 i_write_data,
    output logic [WORD_SIZE-1:0] o_data_in,
    output logic                 o_data_waitreq,
    output logic                 o_proto_err
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    dmem_state_t          r_state;
    dmem_op_t             r_op;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic                 r_in_range;

    logic                 w_req;
    dmem_op_t             w_op;
    logic                 w_in_range;
    logic                 w_access;
    logic                 w_we;
    logic                 w_re;
    logic                 w_clr;
    logic [WORD_SIZE-1:0] w_rdata;

    assign w_req      = i_read_data | i_write_data;
    assign w_op       = decodeOp(i_read_data, i_write_data);
    assign w_in_range = (i_data_addr[WORD_SIZE-1:ADDR_BITS] == '0);

    // Capture the request in IDLE, count down the wait, then spend exactly one cycle in ACK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_op       <= OP_RD;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_in_range <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op       <= w_op;
                        r_cnt      <= CNT_LOAD;
                        r_addr     <= i_data_addr[ADDR_BITS-1:0];
                        r_wdata    <= i_data_out;
                        r_in_range <= w_in_range;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range accesses keep normal timing but never touch the array and return zero.
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_we     = w_access && (r_op == OP_WR) && r_in_range;
    assign w_re     = w_access && (r_op == OP_RD) && r_in_range;
    assign w_clr    = (w_access && !w_re) || (r_state == ACK);

    dmem_array #(
        .WORD_SIZE(WORD_SIZE),
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_clr  (w_clr),
        .i_addr (r_addr),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

    assign o_data_in = w_rdata;

    always_comb begin
        o_data_waitreq = 1'b0;
        case (r_state)
            IDLE:    o_data_waitreq = w_req;
            BUSY:    o_data_waitreq = 1'b1;
            default: o_data_waitreq = 1'b0;
        endcase
    end

`ifdef DMEM_PROTO_CHECK_EN
    logic [WORD_SIZE-1:0] r_chk_addr;
    logic                 r_proto_err;
    logic                 w_hold_err;
    logic                 w_viol;

    always_comb begin
        w_hold_err = 1'b0;
        if (r_state != IDLE) begin
            if (i_data_addr != r_chk_addr) begin
                w_hold_err = 1'b1;
            end
            if (w_req && (w_op != r_op)) begin
                w_hold_err = 1'b1;
            end
            if ((r_op == OP_WR) && (i_data_out != r_wdata)) begin
                w_hold_err = 1'b1;
            end
        end
    end

    assign w_viol = (i_read_data && i_write_data) || w_hold_err || ((r_state == BUSY) && !w_req);

    // The full address is kept here because the array only needs the implemented bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk_addr  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_req) begin
                r_chk_addr <= i_data_addr;
            end
            r_proto_err <= r_proto_err | w_viol;
        end
    end

    assign o_proto_err = r_proto_err;
`else
    assign o_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, corner-case sequences
// and a randomized access stream checked against a simple word-array model.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rdReq;
    logic        wrReq;
    logic        target;

    logic        rd0, wr0, rd1, wr1;
    logic [15:0] dataIn0, dataIn1, dataInSel;
    logic        wait0, wait1, waitSel;
    logic        perr0, perr1, perrSel;

    int vectors;
    int miscompares;

    logic [15:0] model [256];

    typedef struct {
        logic        isWrite;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] expData;
    } vec_t;

    vec_t table_v [12];

    assign rd0 = rdReq & ~target;
    assign wr0 = wrReq & ~target;
    assign rd1 = rdReq & target;
    assign wr1 = wrReq & target;
    assign dataInSel = target ? dataIn1 : dataIn0;
    assign waitSel   = target ? wait1 : wait0;
    assign perrSel   = target ? perr1 : perr0;

    dmem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut0 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_addr   (addr),
        .i_data_out    (wdata),
        .i_read_data   (rd0),
        .i_write_data  (wr0),
        .o_data_in     (dataIn0),
        .o_data_waitreq(wait0),
        .o_proto_err   (perr0)
    );

    dmem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .WAIT_CYCLES(1)) u_dut1 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_addr   (addr),
        .i_data_out    (wdata),
        .i_read_data   (rd1),
        .i_write_data  (wr1),
        .o_data_in     (dataIn1),
        .o_data_waitreq(wait1),
        .o_proto_err   (perr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input logic [15:0] act, input logic [15:0] exp, input string name);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives one access and checks every cycle up to its ACK.
    task automatic applyStimulus(input logic isWrite, input logic [15:0] a, input logic [15:0] d,
                                 input logic [15:0] expData, input int wc, input string name);
        addr  = a;
        wdata = d;
        rdReq = ~isWrite;
        wrReq = isWrite;
        for (int k = 0; k <= wc; k++) begin
            @(negedge clk);
            checkOutput(16'(waitSel), 16'd1, {name, " waitreq busy"});
            checkOutput(dataInSel, 16'h0000, {name, " data busy"});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput(16'(waitSel), 16'd0, {name, " waitreq ack"});
        checkOutput(dataInSel, expData, {name, " data ack"});
        @(posedge clk);
        #1;
        rdReq = 1'b0;
        wrReq = 1'b0;
    endtask

    // Reference model: a plain word array with zero returned outside the implemented range.
    task automatic modelAccess(input logic isWrite, input logic [15:0] a, input logic [15:0] d,
                               input string name);
        logic [15:0] exp;
        logic        inRange;
        inRange = (a[15:8] == 8'h00);
        exp     = 16'h0000;
        if (isWrite) begin
            if (inRange) model[a[7:0]] = d;
        end else if (inRange) begin
            exp = model[a[7:0]];
        end
        applyStimulus(isWrite, a, d, exp, 2, name);
    endtask

    initial begin
        logic        expPerr;
        logic        isW;
        logic [15:0] ra;
        logic [15:0] rdv;

        vectors     = 0;
        miscompares = 0;
        target      = 1'b0;
        addr        = '0;
        wdata       = '0;
        rdReq       = 1'b0;
        wrReq       = 1'b0;
        rst_n       = 1'b0;

`ifdef DMEM_PROTO_CHECK_EN
        expPerr = 1'b1;
`else
        expPerr = 1'b0;
`endif

        table_v[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000};
        table_v[1]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        table_v[2]  = '{1'b1, 16'h0105, 16'h1234, 16'h0000};
        table_v[3]  = '{1'b0, 16'h0105, 16'h0000, 16'h0000};
        table_v[4]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        table_v[5]  = '{1'b1, 16'h00FF, 16'h0F0F, 16'h0000};
        table_v[6]  = '{1'b0, 16'h00FF, 16'h0000, 16'h0F0F};
        table_v[7]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000};
        table_v[8]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5};
        table_v[9]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h0000};
        table_v[10] = '{1'b0, 16'h8000, 16'h0000, 16'h0000};
        table_v[11] = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5};

        // Reset values, including waitreq following a request while held in reset.
        @(negedge clk);
        checkOutput(16'(wait0), 16'd0, "reset waitreq");
        checkOutput(dataIn0, 16'h0000, "reset data");
        checkOutput(16'(perr0), 16'd0, "reset proto");
        rdReq = 1'b1;
        #1;
        checkOutput(16'(wait0), 16'd1, "reset waitreq follows req");
        rdReq = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput(16'(wait0), 16'd0, "post-reset waitreq");
        checkOutput(dataIn0, 16'h0000, "post-reset data");
        checkOutput(16'(perr0), 16'd0, "post-reset proto");
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(table_v[i].isWrite, table_v[i].a, table_v[i].d, table_v[i].expData, 2,
                          $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput(16'(wait0), 16'd0, "idle waitreq");
            checkOutput(dataIn0, 16'h0000, "idle data");
            checkOutput(16'(u_dut0.r_state), 16'(IDLE), "idle state");
            @(posedge clk);
            #1;
        end

        // Reset during the first BUSY cycle of a write abandons it.
        applyStimulus(1'b1, 16'h0007, 16'h5555, 16'h0000, 2, "pre-reset wr7");
        addr  = 16'h0007;
        wdata = 16'hAAAA;
        wrReq = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wrReq = 1'b0;
        #1;
        checkOutput(16'(wait0), 16'd0, "midreset waitreq");
        checkOutput(16'(perr0), 16'd0, "midreset proto");
        checkOutput(dataIn0, 16'h0000, "midreset data");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput(16'(wait0), 16'd0, "after release waitreq");
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 16'h0007, 16'h0000, 16'h5555, 2, "rd7 after reset");

        for (int i = 0; i < 16; i++) begin
            modelAccess(1'b1, 16'(i), 16'($urandom), $sformatf("init%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            isW = 1'($urandom_range(0, 1));
            ra  = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) ra = ra | 16'($urandom_range(1, 255) << 8);
            rdv = 16'($urandom);
            modelAccess(isW, ra, rdv, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Shorter-latency instance: back-to-back reads acknowledge three cycles apart.
        target = 1'b1;
        applyStimulus(1'b1, 16'h0000, 16'h1111, 16'h0000, 1, "wc1 wr0");
        applyStimulus(1'b1, 16'h0001, 16'h2222, 16'h0000, 1, "wc1 wr1");
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h1111, 1, "wc1 rd0");
        applyStimulus(1'b0, 16'h0001, 16'h0000, 16'h2222, 1, "wc1 rd1");
        checkOutput(16'(perr1), 16'd0, "wc1 proto clean");
        target = 1'b0;

        checkOutput(16'(perr0), 16'd0, "proto clean before violation");
        addr  = 16'h0003;
        rdReq = 1'b1;
        @(posedge clk);
        #1;
        addr = 16'h0004;
        @(negedge clk);
        checkOutput(16'(perr0), 16'd0, "proto before edge");
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput(16'(perr0), 16'(expPerr), "proto after addr change");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rdReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput(16'(perr0), 16'(expPerr), "proto sticky");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput(16'(perr0), 16'd0, "proto cleared by reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
